// File: rtl/matrix_scan_bcm.sv
// matrix_scan_bcm: HUB75-style panel scanner with binary-coded modulation.
// The next bit-plane is shifted in while the current one is on display, and a
// global dim value scales the output-enable on-time of every display period.
// Optional build macro MATRIX_SCAN_DEADTIME_EN inserts DEAD_CYCLES of blanking
// before each row latch and after each latch, ahead of the display period.
`default_nettype none

module matrix_scan_bcm #(
  parameter int COLUMNS        = 64,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int BIT_DEPTH      = 6,
  parameter int BASE_ON_CYCLES = 32,
  parameter int DEAD_CYCLES    = 4
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [7:0]                  dim,
  output logic [$clog2(COLUMNS)-1:0]  column_address,
  output logic [ROW_ADDR_WIDTH-1:0]   row_address,
  output logic [ROW_ADDR_WIDTH-1:0]   row_address_active,
  output logic                        pixel_load_start,
  output logic                        clk_pixel,
  output logic                        row_latch,
  output logic                        output_enable,
  output logic [BIT_DEPTH-1:0]        brightness_mask,
  output logic                        frame_start
);

  localparam int COL_W   = $clog2(COLUMNS);
  localparam int PL_W    = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int PER_MAX = BASE_ON_CYCLES << (BIT_DEPTH - 1);
  localparam int CNT_W   = $clog2(PER_MAX + 1);
  localparam int PROD_W  = CNT_W + 9;
`ifdef MATRIX_SCAN_DEADTIME_EN
  localparam int DEAD_EFF = DEAD_CYCLES;
`else
  // Blanking disabled: DEAD_CYCLES has no effect on timing.
  localparam int DEAD_EFF = DEAD_CYCLES * 0;
`endif
  localparam int DEAD_W = (DEAD_EFF > 1) ? $clog2(DEAD_EFF) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_EFF > 0) ? DEAD_EFF - 1 : 0);

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WAIT} ld_state_t;
  typedef enum logic [1:0] {D_DONE, D_LEAD, D_RUN, D_TAIL} dp_state_t;

  ld_state_t                 ld_state, ld_next;
  logic [COL_W-1:0]          col, col_nx;
  logic                      phase, phase_nx;
  logic [BIT_DEPTH-1:0]      mask, mask_nx;
  logic [ROW_ADDR_WIDTH-1:0] row, row_nx;
  logic [ROW_ADDR_WIDTH-1:0] act, act_nx;

  dp_state_t                 dp_state, dp_next;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic [DEAD_W-1:0]         dead, dead_nx;
  logic [CNT_W-1:0]          period, period_nx;
  logic [CNT_W-1:0]          on_cyc, on_nx;

  logic                      latch;
  logic [PL_W-1:0]           plane_idx;
  logic [CNT_W-1:0]          per_load;
  logic [CNT_W-1:0]          per_sel;
  logic [PROD_W-1:0]         on_prod;
  logic [CNT_W-1:0]          on_calc;

  // Latch happens when a plane is fully shifted in and the previous display is over.
  assign latch = (ld_state == L_WAIT) && (dp_state == D_DONE);

  // Period of the plane being loaded and the dimmed on-time of the period about to start.
  always_comb begin
    plane_idx = '0;
    for (int b = 0; b < BIT_DEPTH; b++) begin
      if (mask[b]) plane_idx = PL_W'(b);
    end
    per_load = CNT_W'(BASE_ON_CYCLES) << plane_idx;
    per_sel  = (dp_state == D_DONE) ? per_load : period;
    on_prod  = PROD_W'(per_sel) * PROD_W'({1'b0, dim} + 9'd1);
    on_calc  = CNT_W'(on_prod >> 8);
  end

  // Loader next-state: two cycles per column, then wait for the latch and advance plane/row.
  always_comb begin
    ld_next  = ld_state;
    col_nx   = col;
    phase_nx = phase;
    mask_nx  = mask;
    row_nx   = row;
    act_nx   = act;
    case (ld_state)
      L_IDLE: ld_next = L_LOAD;
      L_LOAD: begin
        if (!phase) begin
          phase_nx = 1'b1;
        end else begin
          phase_nx = 1'b0;
          if (col == COL_W'(COLUMNS - 1)) begin
            col_nx  = '0;
            ld_next = L_WAIT;
          end else begin
            col_nx = col + COL_W'(1);
          end
        end
      end
      L_WAIT: begin
        if (latch) begin
          act_nx  = row;
          ld_next = L_LOAD;
          if (mask[BIT_DEPTH-1]) begin
            mask_nx = BIT_DEPTH'(1);
            row_nx  = row + ROW_ADDR_WIDTH'(1);
          end else begin
            mask_nx = mask << 1;
          end
        end
      end
      default: ld_next = L_IDLE;
    endcase
  end

  // Loader state register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ld_state <= L_IDLE;
      col      <= '0;
      phase    <= 1'b0;
      mask     <= BIT_DEPTH'(1);
      row      <= '0;
      act      <= '0;
    end else begin
      ld_state <= ld_next;
      col      <= col_nx;
      phase    <= phase_nx;
      mask     <= mask_nx;
      row      <= row_nx;
      act      <= act_nx;
    end
  end

  // Display next-state: optional leading blank, timed period, optional trailing blank.
  always_comb begin
    dp_next   = dp_state;
    cnt_nx    = cnt;
    dead_nx   = dead;
    period_nx = period;
    on_nx     = on_cyc;
    case (dp_state)
      D_DONE: begin
        if (latch) begin
          period_nx = per_load;
          cnt_nx    = '0;
          dead_nx   = '0;
          if (DEAD_EFF > 0) begin
            dp_next = D_LEAD;
          end else begin
            dp_next = D_RUN;
            on_nx   = on_calc;
          end
        end
      end
      D_LEAD: begin
        if (dead == DEAD_LAST) begin
          dead_nx = '0;
          dp_next = D_RUN;
          on_nx   = on_calc;
        end else begin
          dead_nx = dead + DEAD_W'(1);
        end
      end
      D_RUN: begin
        if (cnt == period - CNT_W'(1)) begin
          cnt_nx  = '0;
          dp_next = (DEAD_EFF > 0) ? D_TAIL : D_DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      D_TAIL: begin
        if (dead == DEAD_LAST) begin
          dead_nx = '0;
          dp_next = D_DONE;
        end else begin
          dead_nx = dead + DEAD_W'(1);
        end
      end
      default: dp_next = D_DONE;
    endcase
  end

  // Display state register; idle after reset counts as a finished display.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      dp_state <= D_DONE;
      cnt      <= '0;
      dead     <= '0;
      period   <= '0;
      on_cyc   <= '0;
    end else begin
      dp_state <= dp_next;
      cnt      <= cnt_nx;
      dead     <= dead_nx;
      period   <= period_nx;
      on_cyc   <= on_nx;
    end
  end

  assign column_address     = col;
  assign row_address        = row;
  assign row_address_active = act;
  assign brightness_mask    = mask;
  assign pixel_load_start   = (ld_state == L_LOAD) && !phase;
  assign clk_pixel          = (ld_state == L_LOAD) && phase;
  assign row_latch          = latch;
  assign output_enable      = (dp_state == D_RUN) && (cnt < on_cyc);
  assign frame_start        = latch && mask[0] && (row == '0);

endmodule

`default_nettype wire
